// File: rtl/demux_dispatcher.sv
// Sequenced 1-to-4 demultiplexer: accepts one word at a time, routes it by explicit select or
// round-robin, holds it until the chosen consumer accepts it or an optional timeout drops it.
module demux_dispatcher #(
  parameter int unsigned W       = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic [1:0]   in_dest,
  input  logic         rr_mode,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic [W-1:0] d,
  output logic [3:0]   out_valid,
  input  logic [3:0]   out_ready,
  output logic         busy,
  output logic         drop,
  input  logic [1:0]   cnt_sel,
  output logic [7:0]   cnt_out
);

  typedef enum logic [0:0] {StIdle, StDrive} state_e;

  localparam bit         TimeoutEn = (TIMEOUT != 0);
  localparam logic [7:0] LastWait  = 8'(TIMEOUT - 1);

  state_e         state_q;
  logic [W-1:0]   hold_q;
  logic [1:0]     sel_q;
  logic [1:0]     rr_ptr_q;
  logic [7:0]     wait_q;
  logic           drop_q;
  logic [7:0]     cnt_q [4];

  logic deliver;
  logic expire;

  assign deliver = out_ready[sel_q];
  // Delivery wins over a timeout landing in the same cycle.
  assign expire  = TimeoutEn && !deliver && (wait_q == LastWait);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      hold_q   <= '0;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      wait_q   <= '0;
      drop_q   <= 1'b0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      drop_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            state_q <= StDrive;
            hold_q  <= in_data;
            sel_q   <= rr_mode ? rr_ptr_q : in_dest;
            wait_q  <= '0;
            if (rr_mode) rr_ptr_q <= rr_ptr_q + 2'd1;
          end
        end
        StDrive: begin
          if (deliver) begin
            state_q <= StIdle;
            if (cnt_q[sel_q] != 8'hff) cnt_q[sel_q] <= cnt_q[sel_q] + 8'd1;
          end else if (expire) begin
            state_q <= StIdle;
            drop_q  <= 1'b1;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready = (state_q == StIdle);
  assign busy     = (state_q == StDrive);
  assign drop     = drop_q;
  assign cnt_out  = cnt_q[cnt_sel];

  always_comb begin
    out_valid = '0;
    a         = '0;
    b         = '0;
    c         = '0;
    d         = '0;
    if (busy) begin
      out_valid[sel_q] = 1'b1;
      unique case (sel_q)
        2'd0:    a = hold_q;
        2'd1:    b = hold_q;
        2'd2:    c = hold_q;
        default: d = hold_q;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_dispatcher.sv
// Scoreboard bench for demux_dispatcher: the driver pushes expected routing per accepted word,
// a negedge monitor compares channel outputs, drop timing and delivery counts.
module tb_demux_dispatcher;

  localparam int Tmo = 15;

  typedef struct {
    logic [1:0] ch;
    logic [3:0] data;
  } item_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = '0;
  logic [1:0] in_dest = '0;
  logic       rr_mode = 1'b0;
  logic [3:0] a, b, c, d;
  logic [3:0] out_valid;
  logic [3:0] out_ready = '0;
  logic       busy;
  logic       drop;
  logic [1:0] cnt_sel = '0;
  logic [7:0] cnt_out;

  demux_dispatcher #(.W(4), .TIMEOUT(Tmo)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .rr_mode   (rr_mode),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .drop      (drop),
    .cnt_sel   (cnt_sel),
    .cnt_out   (cnt_out)
  );

  always #5 clk = ~clk;

  logic [3:0] chan [4];
  assign chan[0] = a;
  assign chan[1] = b;
  assign chan[2] = c;
  assign chan[3] = d;

  // Reference model state
  item_t      sb_q [$];
  logic [1:0] m_rr = '0;
  int         m_cnt [4] = '{0, 0, 0, 0};
  int         m_wait = 0;
  logic       exp_drop = 1'b0;
  item_t      mon_it;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle, compare DUT against the word the model says is held.
  always @(negedge clk) begin
    if (!rst) begin
      check("drop", drop, exp_drop);
      exp_drop = 1'b0;
      check("in_ready", in_ready, sb_q.size() == 0);
      check("busy", busy, sb_q.size() != 0);
      check("cnt_out", cnt_out, m_cnt[cnt_sel]);
      if (sb_q.size() == 0) begin
        check("out_valid_idle", out_valid, 0);
        for (int i = 0; i < 4; i++) check("chan_idle", chan[i], 0);
      end else begin
        mon_it = sb_q[0];
        check("out_valid", out_valid, 4'b0001 << mon_it.ch);
        for (int i = 0; i < 4; i++)
          check("chan_data", chan[i], (i == int'(mon_it.ch)) ? mon_it.data : 4'd0);
        if (out_ready[mon_it.ch]) begin
          void'(sb_q.pop_front());
          if (m_cnt[mon_it.ch] < 255) m_cnt[mon_it.ch]++;
          m_wait = 0;
        end else begin
          m_wait++;
          if (m_wait == Tmo) begin
            void'(sb_q.pop_front());
            m_wait   = 0;
            exp_drop = 1'b1;
          end
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the accept edge.
  task automatic send(input logic [3:0] data, input logic [1:0] dest, input logic rr,
                      input logic [3:0] rdy, input bit rnd);
    item_t it;
    int n = 0;
    while (!in_ready && n < 200) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 4'($urandom);
      if (rnd) out_ready = 4'($urandom);
      cycle();
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_wait: in_ready still %0b after %0d cycles, required 1", in_ready, n);
    end
    in_valid  = 1'b1;
    in_data   = data;
    in_dest   = dest;
    rr_mode   = rr;
    out_ready = rdy;
    it.ch     = rr ? m_rr : dest;
    it.data   = data;
    if (rr) m_rr = m_rr + 2'd1;
    cycle();
    sb_q.push_back(it);
    in_valid = 1'b0;
    in_dest  = 2'($urandom);
    rr_mode  = 1'($urandom);
    cnt_sel  = 2'($urandom);
  endtask

  task automatic check_counts(input int exp0, input int exp1, input int exp2, input int exp3);
    int e [4];
    e = '{exp0, exp1, exp2, exp3};
    for (int i = 0; i < 4; i++) begin
      cnt_sel = 2'(i);
      #1;
      check("cnt_direct", cnt_out, e[i]);
    end
  endtask

  initial begin
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop, 0);
    check("rst_cnt", cnt_out, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();

    // Explicit destinations, all consumers ready
    for (int i = 0; i < 4; i++) send(4'b1011, 2'(i), 1'b0, 4'b1111, 1'b0);
    repeat (2) cycle();
    check_counts(1, 1, 1, 1);
    cycle();

    // Round-robin, in_dest ignored
    for (int i = 1; i <= 5; i++) send(4'(i), 2'd3, 1'b1, 4'b1111, 1'b0);
    repeat (2) cycle();

    // Back-pressure, then a stalled follow-up word
    send(4'hc, 2'd2, 1'b0, 4'b0000, 1'b0);
    repeat (3) cycle();
    out_ready = 4'b0100;
    send(4'h5, 2'd0, 1'b0, 4'b0001, 1'b0);
    repeat (2) cycle();

    // Timeout on channel b
    send(4'h9, 2'd1, 1'b0, 4'b0000, 1'b0);
    repeat (Tmo + 3) cycle();

    // Delivery in the very cycle the timeout would fire
    send(4'h3, 2'd3, 1'b0, 4'b0000, 1'b0);
    repeat (Tmo - 1) cycle();
    out_ready = 4'b1000;
    repeat (2) cycle();

    // Randomised traffic
    for (int i = 0; i < 120; i++) begin
      send(4'($urandom), 2'($urandom), 1'($urandom), 4'($urandom), 1'b1);
      repeat ($urandom_range(0, 3)) begin
        out_ready = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
        cycle();
      end
    end
    out_ready = 4'b1111;
    repeat (3) cycle();

    // Async reset mid-DRIVE with pointer at 2
    while (m_rr != 2'd2) send(4'h6, 2'd0, 1'b1, 4'b1111, 1'b0);
    repeat (2) cycle();
    send(4'h7, 2'd0, 1'b1, 4'b0000, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_c", c, 0);
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_drop", drop, 0);
    sb_q.delete();
    m_rr     = '0;
    m_cnt    = '{0, 0, 0, 0};
    m_wait   = 0;
    exp_drop = 1'b0;
    check_counts(0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();
    send(4'ha, 2'd3, 1'b1, 4'b1111, 1'b0);
    repeat (3) cycle();

    begin
      int n = 0;
      out_ready = 4'b1111;
      while (sb_q.size() != 0 && n < 100) begin
        cycle();
        n++;
      end
      if (sb_q.size() != 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL drain: %0d words outstanding, required 0", sb_q.size());
      end
    end
    cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached with %0d words outstanding", sb_q.size());
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/demux_dispatcher.md
# demux_dispatcher

Sequenced 1-to-4 demultiplexer controller. It accepts words on a valid/ready input port and routes each one to exactly one of four output channels (a, b, c, d). The destination comes from an explicit select or from an internal round-robin pointer. Each routed word is held until that channel's consumer accepts it, or until a programmable timeout drops it. The block sits between a single producer and four consumers, replacing the bare combinational demux where back-pressure and sharing are needed.

## Interface
- W, default 4: data width of input and of each output channel.
- TIMEOUT, default 15: cycles a held word waits for out_ready before being dropped; 0 means wait forever. 8-bit range (0..255).
- clk, input, 1: sole clock; all state changes on the rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- in_valid, input, 1: producer has a word.
- in_ready, output, 1: block can accept a word this cycle.
- in_data, input, W: word to route.
- in_dest, input, 2: destination select when rr_mode=0 (0=a, 1=b, 2=c, 3=d).
- rr_mode, input, 1: 1 means the destination comes from the round-robin pointer and in_dest is ignored.
- a, b, c, d, output, W each: channel data; the selected channel carries the held word, all others read 0.
- out_valid, output, 4: one-hot channel valid (bit0=a … bit3=d).
- out_ready, input, 4: per-channel consumer ready.
- busy, output, 1: a word is held (DRIVE state).
- drop, output, 1: one-cycle pulse when a held word times out.
- cnt_sel, input, 2: selects the channel for cnt_out.
- cnt_out, output, 8: delivered-word count of channel cnt_sel; combinational read of registered counters.

## Operation
- FSM states:
  - IDLE: in_ready=1, busy=0, out_valid=0, a..d=0.
  - DRIVE: in_ready=0, busy=1, out_valid[sel]=1, channel sel driven with the held word.
- IDLE→DRIVE on in_valid=1 (handshake). At that edge the block latches:
  - in_data into hold_data;
  - sel = rr_mode ? rr_ptr : in_dest.
- Round-robin pointer:
  - rr_ptr is 2-bit and advances by 1 (mod 4) on every accept made with rr_mode=1.
  - The advance happens whether that word is later delivered or dropped.
  - Accepts with rr_mode=0 leave rr_ptr unchanged.
- DRIVE→IDLE on delivery (out_ready[sel]=1):
  - cnt[sel] increments, saturating at 255.
  - out_ready bits of unselected channels are ignored.
- DRIVE→IDLE on timeout:
  - wait_cnt (8-bit) clears at entry to DRIVE and increments each DRIVE cycle with out_ready[sel]=0.
  - When TIMEOUT≠0 and wait_cnt==TIMEOUT-1 in a non-ready cycle, the next edge returns to IDLE.
  - drop is high for exactly the first IDLE cycle after that edge.
  - Dropped words are not counted.
  - Delivery takes priority over timeout in the same cycle.
- rr_mode and in_dest changes during DRIVE have no effect on the held word.
- hold_data and sel are stable throughout DRIVE.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, a=b=c=d=0, out_valid=0, busy=0, drop=0;
  - rr_ptr=0, wait_cnt=0, all cnt=0 (so cnt_out=0).
- Reset asserted mid-DRIVE discards the held word immediately (asynchronously); no drop pulse.
- Latency: word accepted at edge N appears on its channel with out_valid from edge N (the cycle after the accept cycle).
- Transfer completes at the first edge with out_ready[sel]=1. out_ready already high on entry gives a transfer one cycle after accept.
- in_ready=0 for the whole of DRIVE and returns to 1 in the cycle after completion.
- Maximum throughput is one word per 2 cycles.
- Timeout: with out_ready held low, a word accepted at edge N is dropped at edge N+TIMEOUT, and drop is high in cycle N+TIMEOUT.
- All outputs except cnt_out are registered or decoded purely from registered state.

## Test plan
- Reset, then rr_mode=0 with in_data=4'b1011 and in_dest=0,1,2,3 in turn, out_ready=4'b1111 → each word appears on a, b, c, d respectively for one cycle with the matching out_valid one-hot (0001, 0010, 0100, 1000); other channels read 0; cnt_out=1 for each channel.
- rr_mode=1, five accepts of data 1..5 with in_dest held at 3 → words 1..5 route to a, b, c, d, a; final rr_ptr=1.
- Back-pressure: in_dest=2, out_ready=0 for 3 cycles, then 4'b0100 → c holds the word for 4 cycles, in_ready=0 meanwhile, in_valid stalls, no drop, delivery on the 4th cycle.
- Timeout: TIMEOUT=15, out_ready=0, in_dest=1 → drop pulses exactly 15 cycles after the accept edge; cnt for b unchanged; in_ready returns to 1.
- Delivery in the same cycle timeout would fire (out_ready[sel] rises in the last wait cycle) → word delivered, count incremented, no drop.
- Reset asserted asynchronously mid-DRIVE with rr_ptr=2 → outputs go to 0 immediately, rr_ptr=0, counters 0, no drop. The next accept in rr_mode routes to a.
